gray_rx_checker: RTL
====================

# gray_rx_checker

Downstream consumer of the `gray_ctr` output. It registers the incoming Gray code and converts it to binary. It then checks every sample against the previous one and classifies it as a legal single-step advance, a hold, or an illegal jump, tracking lock status, wraps and errors. It sits directly on `q` of `gray_ctr`, shares its clock and reset, and hands a clean binary count plus health flags to downstream logic.

## Interface
- `WIDTH`, 4: Gray/binary code width; must match the upstream counter.
- `SYNC_LEN`, 3: consecutive legal steps required to regain lock after an error; ≥1.
- `ERR_W`, 8: width of the saturating error counter.
- `WRAP_W`, 8: width of the free-running wrap counter.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset, shared with `gray_ctr`.
- `g_in`  input  WIDTH  Gray code from upstream `q`.
- `bin`  output  WIDTH  registered binary equivalent of the sampled code.
- `bin_valid`  output  1  `bin` holds a real converted sample.
- `locked`  output  1  state is LOCKED.
- `step_ok`  output  1  one-cycle pulse: sample was previous+1 (mod 2^WIDTH).
- `hold`  output  1  one-cycle pulse: sample equals previous.
- `step_err`  output  1  one-cycle pulse: any other transition.
- `wrap`  output  1  one-cycle pulse: legal step from 2^WIDTH−1 to 0.
- `err_cnt`  output  ERR_W  count of `step_err` pulses, saturating at all-ones.
- `wrap_cnt`  output  WRAP_W  count of `wrap` pulses, modulo 2^WRAP_W.

## Operation
- Input stage: `g_r <= g_in` every edge when not in reset. The value `cur = gray2bin(g_r)` is computed combinationally, with bit i of cur equal to the XOR of g_r[WIDTH-1:i].
- Reset (asynchronous, immediate) clears the following: state=INIT, `g_r`=0, `bin`=0, `bin_valid`=0, `locked`=0, all pulses 0, `err_cnt`=0, `wrap_cnt`=0, good-run counter=0.
- Classification uses `cur` against `prev` = current `bin`. The three outcomes are mutually exclusive:
  - STEP: `cur == prev+1` mod 2^WIDTH. If `prev` is all-ones, it is also a WRAP.
  - HOLD: `cur == prev`.
  - ERR: anything else, including a backwards step (`prev−1`).
- FSM:
  - INIT: `g_r` captures the first sample. Go to PRIME. No outputs change.
  - PRIME: `bin <= cur`, `bin_valid <= 1`, no classification, no pulses. Go to LOCKED.
  - LOCKED: `bin <= cur` and classify.
    - STEP or HOLD: stay in LOCKED.
    - ERR: go to RESYNC and clear the good-run counter.
  - RESYNC: `bin <= cur` and classify.
    - STEP: increment the good-run counter. On the SYNC_LEN-th consecutive STEP, go to LOCKED.
    - HOLD: good-run counter unchanged.
    - ERR: clear the good-run counter.
- Pulses and counters are active in both LOCKED and RESYNC.
  - `err_cnt` increments on every ERR. At all-ones it holds.
  - `wrap_cnt` increments on every WRAP and rolls over.
- `locked` is registered and equals (next state == LOCKED).
- `bin_valid` stays 1 until reset.

## Timing
- A `g_in` change sampled at edge n appears in `g_r` after edge n. The corresponding `bin` and pulses update at edge n+1, giving 2-edge latency from input to output.
- First reset release, with release before edge 0:
  - Edge 0: INIT→PRIME.
  - Edge 1: `bin_valid` and `locked` go to 1, and `bin` = gray2bin of the value sampled at edge 0.
  - Edge 2: first classification.
- Pulses are high for exactly one cycle per qualifying edge. Back-to-back STEPs give `step_ok` continuously high.
- Reset mid-operation clears everything asynchronously, with no waiting for `clk`. After release, the block repeats INIT→PRIME, with no error counted for the discontinuity.
- Reset has priority over every simultaneous event.

## Test plan
- Lock and track (WIDTH=4): release reset and free-run `gray_ctr` → `bin` = 0,1,2,… two edges behind `g_in`; `locked`=1 from the second edge onward; `step_ok` continuously high; `step_err` never asserts.
- Wrap: run 20 steps from 0 → `wrap` pulses exactly once, when `bin` goes 15→0; `wrap_cnt`=1; `locked` stays 1.
- Hold: drive `g_in`=0110 (binary 4) for 3 cycles → 2 `hold` pulses follow the step into 4; `err_cnt`=0; `locked`=1.
- Jump and resync (SYNC_LEN=3): drive 0010 (3) then 0111 (5) → one `step_err` pulse; `err_cnt`=1; `locked` falls. Next drive 0101 (6), 0100 (7), 1100 (8) → `locked` is back to 1 on the edge classifying 8. Backwards 0100 (7) to 0101 (6) is also an ERR.
- Saturation (ERR_W=2): inject 5 illegal jumps → `err_cnt` = 1,2,3,3,3.
- Async reset mid-run: assert `reset` between clock edges while `bin`=9 → all outputs 0 immediately. After release, INIT→PRIME occurs and `err_cnt` stays 0.

Source files
------------

// File: rtl/gray_rx_checker.sv
// Gray-code receiver: registers an upstream Gray count, converts it to binary and
// classifies each sample as a step, hold or illegal jump while tracking lock health.
module gray_rx_checker #(
    parameter int WIDTH    = 4,
    parameter int SYNC_LEN = 3,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  g_in,
    output logic [WIDTH-1:0]  bin,
    output logic              bin_valid,
    output logic              locked,
    output logic              step_ok,
    output logic              hold,
    output logic              step_err,
    output logic              wrap,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam int RUN_W = (SYNC_LEN < 2) ? 1 : $clog2(SYNC_LEN + 1);

    typedef enum logic [1:0] {INIT, PRIME, LOCKED, RESYNC} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  g_q;
    logic [WIDTH-1:0]  bin_q;
    logic [WIDTH-1:0]  bin_d;
    logic              bin_valid_q;
    logic              locked_q;
    logic              step_ok_q;
    logic              hold_q;
    logic              step_err_q;
    logic              wrap_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [WRAP_W-1:0] wrap_cnt_q;
    logic [RUN_W-1:0]  run_q;

    logic is_step;
    logic is_hold;
    logic is_err;
    logic is_wrap;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_d[i] = ^(g_q >> i);
        end
    end

    always_comb begin
        is_step = (bin_d == bin_q + WIDTH'(1));
        is_hold = (bin_d == bin_q);
        is_err  = !is_step && !is_hold;
        is_wrap = is_step && (bin_q == '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            g_q         <= '0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            step_ok_q   <= 1'b0;
            hold_q      <= 1'b0;
            step_err_q  <= 1'b0;
            wrap_q      <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
            run_q       <= '0;
        end else begin
            g_q        <= g_in;
            step_ok_q  <= 1'b0;
            hold_q     <= 1'b0;
            step_err_q <= 1'b0;
            wrap_q     <= 1'b0;
            case (state_q)
                INIT: begin
                    state_q  <= PRIME;
                    locked_q <= 1'b0;
                end
                PRIME: begin
                    bin_q       <= bin_d;
                    bin_valid_q <= 1'b1;
                    state_q     <= LOCKED;
                    locked_q    <= 1'b1;
                end
                LOCKED, RESYNC: begin
                    bin_q      <= bin_d;
                    step_ok_q  <= is_step;
                    hold_q     <= is_hold;
                    step_err_q <= is_err;
                    wrap_q     <= is_wrap;
                    if (is_wrap) begin
                        wrap_cnt_q <= wrap_cnt_q + WRAP_W'(1);
                    end
                    if (is_err && (err_cnt_q != '1)) begin
                        err_cnt_q <= err_cnt_q + ERR_W'(1);
                    end
                    // Lock is regained only after SYNC_LEN uninterrupted steps; holds neither help nor hurt.
                    if (is_err) begin
                        state_q  <= RESYNC;
                        locked_q <= 1'b0;
                        run_q    <= '0;
                    end else if (state_q == LOCKED) begin
                        locked_q <= 1'b1;
                    end else if (is_step) begin
                        if (run_q == RUN_W'(SYNC_LEN - 1)) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                            run_q    <= '0;
                        end else begin
                            run_q    <= run_q + RUN_W'(1);
                            locked_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= INIT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign bin       = bin_q;
    assign bin_valid = bin_valid_q;
    assign locked    = locked_q;
    assign step_ok   = step_ok_q;
    assign hold      = hold_q;
    assign step_err  = step_err_q;
    assign wrap      = wrap_q;
    assign err_cnt   = err_cnt_q;
    assign wrap_cnt  = wrap_cnt_q;

endmodule
